esfa_cmd_sequencer: RTL and testbench



---
 rtl/esfa_cmd_sequencer_pkg.sv | 27 ++
 rtl/esfa_cmd_sequencer_if.sv | 37 +++
 rtl/esfa_cmd_sequencer_uop_rom.sv | 57 +++++
 rtl/esfa_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_esfa_cmd_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/esfa_cmd_sequencer_pkg.sv
// Shared constants for the ESFA command sequencer: core selector codes,
// opcodes, FSM state encoding and micro-program lengths.
package esfa_pkg;

  localparam logic [3:0] SEL_LOOKUP = 4'd1;
  localparam logic [3:0] SEL_CODE   = 4'd2;
  localparam logic [3:0] SEL_COMMIT = 4'd3;
  localparam logic [3:0] SEL_AVAIL  = 4'd5;
  localparam logic [3:0] SEL_RANK   = 4'd6;
  localparam logic [3:0] SEL_HOLD   = 4'd8;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_UPDATE  = 2'b01;
  localparam logic [1:0] OP_ALLOC   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int unsigned LEN_READ   = 2;
  localparam int unsigned LEN_ALLOC  = 1;
  localparam int unsigned LEN_UPDATE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/esfa_cmd_sequencer_if.sv
// Command, response and core-facing buses of the sequencer. The sequencer
// is the slave of the command stream; the environment/core side is master.
interface esfa_cmd_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_handle;
  logic [DATA_W-1:0] cmd_index;
  logic [DATA_W-1:0] cmd_value;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_ok;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_value;
  logic [DATA_W-1:0] core_queried_handle;
  logic [DATA_W-1:0] core_new_index;
  logic [DATA_W-1:0] core_new_value;
  logic [DATA_W-1:0] core_selector;
  logic              core_result_bool;
  logic [DATA_W-1:0] core_result_value;

  modport slave (
    input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, rsp_ready,
           core_result_bool, core_result_value,
    output cmd_ready, rsp_valid, rsp_ok, rsp_err, rsp_value,
           core_queried_handle, core_new_index, core_new_value, core_selector
  );

  modport master (
    output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, rsp_ready,
           core_result_bool, core_result_value,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_err, rsp_value,
           core_queried_handle, core_new_index, core_new_value, core_selector
  );
endinterface

// File: rtl/esfa_cmd_sequencer_uop_rom.sv
// Micro-program table: maps (opcode, step) to the core selector plus the
// flags that tell the sequencer how to treat the results of that step.
module esfa_uop_rom
  import esfa_pkg::*;
(
  input  logic [1:0] op,
  input  logic [1:0] step,
  output logic [3:0] sel,
  output logic       last_step,
  output logic       capture_as_result,
  output logic       abort_check
);

  always_comb begin
    sel               = SEL_HOLD;
    last_step         = 1'b1;
    capture_as_result = 1'b0;
    abort_check       = 1'b0;
    case (op)
      OP_READ: begin
        last_step = (step == 2'(LEN_READ - 1));
        case (step)
          2'd0: sel = SEL_CODE;
          2'd1: begin
            sel               = SEL_LOOKUP;
            capture_as_result = 1'b1;
          end
          default: sel = SEL_HOLD;
        endcase
      end
      OP_ALLOC: begin
        last_step = (step == 2'(LEN_ALLOC - 1));
        if (step == 2'd0) begin
          sel               = SEL_AVAIL;
          capture_as_result = 1'b1;
        end
      end
      OP_UPDATE: begin
        last_step = (step == 2'(LEN_UPDATE - 1));
        case (step)
          2'd0: sel = SEL_CODE;
          // Free-slot probe: its handle becomes the response value, and a
          // false result means the array is full and the update aborts.
          2'd1: begin
            sel               = SEL_AVAIL;
            capture_as_result = 1'b1;
            abort_check       = 1'b1;
          end
          2'd2: sel = SEL_RANK;
          default: sel = SEL_COMMIT;
        endcase
      end
      default: sel = SEL_HOLD;
    endcase
  end

endmodule

// File: rtl/esfa_cmd_sequencer.sv
// Expands READ/UPDATE/ALLOC commands into timed core selector micro-ops and
// returns one response per command; one command in flight at a time.
module esfa_cmd_sequencer
  import esfa_pkg::*;
#(
  parameter int STEP_CYCLES = 2,
  parameter int DATA_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  esfa_cmd_sequencer_if.slave bus,
  output logic                busy
);

  state_t            state, state_nxt;
  logic [1:0]        op_r;
  logic [1:0]        step;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] handle_r, index_r, value_r;
  logic              rsp_ok_r, rsp_err_r;
  logic [DATA_W-1:0] rsp_value_r;

  logic [3:0] rom_sel;
  logic       rom_last, rom_capture, rom_abort_check;
  logic       accept, sample, abort;

  esfa_uop_rom u_rom (
    .op                (op_r),
    .step              (step),
    .sel               (rom_sel),
    .last_step         (rom_last),
    .capture_as_result (rom_capture),
    .abort_check       (rom_abort_check)
  );

  assign accept = bus.cmd_valid && (state == ST_IDLE);
  assign sample = (state == ST_STEP) && (cnt == 4'(STEP_CYCLES - 1));
  assign abort  = sample && rom_abort_check && !bus.core_result_bool;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.cmd_ready     = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.core_selector = DATA_W'(SEL_HOLD);
    busy              = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (accept) state_nxt = (bus.cmd_op == OP_ILLEGAL) ? ST_RESP : ST_STEP;
      end
      ST_STEP: begin
        bus.core_selector = DATA_W'(rom_sel);
        if (sample && (rom_last || abort)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, step/cycle counters and result capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r        <= OP_READ;
      step        <= 2'd0;
      cnt         <= 4'd0;
      handle_r    <= '0;
      index_r     <= '0;
      value_r     <= '0;
      rsp_ok_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_value_r <= '0;
    end else if (accept) begin
      op_r      <= bus.cmd_op;
      handle_r  <= bus.cmd_handle;
      index_r   <= bus.cmd_index;
      value_r   <= bus.cmd_value;
      step      <= 2'd0;
      cnt       <= 4'd0;
      rsp_err_r <= (bus.cmd_op == OP_ILLEGAL);
      if (bus.cmd_op == OP_ILLEGAL) begin
        rsp_ok_r    <= 1'b0;
        rsp_value_r <= '0;
      end
    end else if (state == ST_STEP) begin
      if (sample) begin
        cnt <= 4'd0;
        if (rom_capture) rsp_value_r <= bus.core_result_value;
        if (abort) begin
          rsp_ok_r    <= 1'b0;
          rsp_value_r <= '0;
        end else if (rom_last) begin
          rsp_ok_r <= bus.core_result_bool;
        end else begin
          step <= step + 2'd1;
        end
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign bus.rsp_ok              = rsp_ok_r;
  assign bus.rsp_err             = rsp_err_r;
  assign bus.rsp_value           = rsp_value_r;
  assign bus.core_queried_handle = handle_r;
  assign bus.core_new_index      = index_r;
  assign bus.core_new_value      = value_r;

endmodule

// File: tb/tb_esfa_cmd_sequencer.sv
// Randomized bench for esfa_cmd_sequencer: a table-driven core stand-in and a
// list-based model of each command's selector sequence and response.
module tb_esfa_cmd_sequencer;
  import esfa_pkg::*;

  localparam int DW = 8;
  localparam int SC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;

  esfa_cmd_sequencer_if #(.DATA_W(DW)) bus ();

  esfa_cmd_sequencer #(.STEP_CYCLES(SC), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: each selector code returns a fixed (bool, value) pair.
  logic          tbl_bool [16];
  logic [DW-1:0] tbl_val  [16];
  assign bus.core_result_bool  = tbl_bool[bus.core_selector[3:0]];
  assign bus.core_result_value = tbl_val[bus.core_selector[3:0]];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_core();
    for (int s = 0; s < 16; s++) begin
      tbl_bool[s] = 1'($urandom);
      tbl_val[s]  = DW'($urandom);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] h, input logic [DW-1:0] ix,
                         input logic [DW-1:0] v, input int hold, input bit noisy);
    int            seq[$];
    logic          e_ok, e_err;
    logic [DW-1:0] e_val;
    e_err = 1'b0;
    e_ok  = 1'b0;
    e_val = '0;
    seq   = {};
    case (op)
      2'b00: begin seq = {2, 1}; e_ok = tbl_bool[1]; e_val = tbl_val[1]; end
      2'b10: begin seq = {5};    e_ok = tbl_bool[5]; e_val = tbl_val[5]; end
      2'b01: begin
        if (!tbl_bool[5]) begin
          seq = {2, 5};
        end else begin
          seq = {2, 5, 6, 3}; e_ok = tbl_bool[3]; e_val = tbl_val[5];
        end
      end
      default: e_err = 1'b1;
    endcase

    @(negedge clk);
    check_eq("idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_handle = h;
    bus.cmd_index  = ix;
    bus.cmd_value  = v;
    @(posedge clk);
    #1;
    if (noisy) begin
      bus.cmd_op     = 2'($urandom);
      bus.cmd_handle = DW'($urandom);
      bus.cmd_index  = DW'($urandom);
      bus.cmd_value  = DW'($urandom);
    end else begin
      bus.cmd_valid = 1'b0;
    end

    foreach (seq[i]) begin
      for (int c = 0; c < SC; c++) begin
        @(negedge clk);
        check_eq("step_selector", bus.core_selector, seq[i]);
        check_eq("step_rsp_valid", bus.rsp_valid, 0);
        check_eq("step_cmd_ready", bus.cmd_ready, 0);
        check_eq("step_busy", busy, 1);
        check_eq("step_handle", bus.core_queried_handle, h);
        check_eq("step_index", bus.core_new_index, ix);
        check_eq("step_value", bus.core_new_value, v);
      end
    end

    @(negedge clk);
    check_eq("rsp_valid", bus.rsp_valid, 1);
    check_eq("rsp_ok", bus.rsp_ok, e_ok);
    check_eq("rsp_err", bus.rsp_err, e_err);
    check_eq("rsp_value", bus.rsp_value, e_val);
    check_eq("rsp_selector_hold", bus.core_selector, 8);
    check_eq("rsp_cmd_ready", bus.cmd_ready, 0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", bus.rsp_valid, 1);
      check_eq("hold_rsp_ok", bus.rsp_ok, e_ok);
      check_eq("hold_rsp_err", bus.rsp_err, e_err);
      check_eq("hold_rsp_value", bus.rsp_value, e_val);
      check_eq("hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("post_rsp_valid", bus.rsp_valid, 0);
    check_eq("post_cmd_ready", bus.cmd_ready, 1);
    check_eq("post_busy", busy, 0);
    check_eq("post_selector", bus.core_selector, 8);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'b00;
    bus.cmd_handle = '0;
    bus.cmd_index  = '0;
    bus.cmd_value  = '0;
    bus.rsp_ready  = 1'b0;
    randomize_core();

    repeat (3) @(negedge clk);
    check_eq("reset_cmd_ready", bus.cmd_ready, 1);
    check_eq("reset_rsp_valid", bus.rsp_valid, 0);
    check_eq("reset_rsp_ok", bus.rsp_ok, 0);
    check_eq("reset_rsp_err", bus.rsp_err, 0);
    check_eq("reset_rsp_value", bus.rsp_value, 0);
    check_eq("reset_selector", bus.core_selector, 8);
    check_eq("reset_handle", bus.core_queried_handle, 0);
    check_eq("reset_index", bus.core_new_index, 0);
    check_eq("reset_value", bus.core_new_value, 0);
    check_eq("reset_busy", busy, 0);
    reset = 1'b1;

    // Directed scenarios.
    tbl_bool[1] = 1'b1; tbl_val[1] = 8'h5A;
    run_cmd(2'b00, 8'd3, 8'd4, 8'd0, 0, 1'b0);
    tbl_bool[5] = 1'b1; tbl_val[5] = 8'h06;
    run_cmd(2'b10, 8'd9, 8'd0, 8'd0, 4, 1'b0);
    tbl_bool[5] = 1'b1; tbl_val[5] = 8'h04; tbl_bool[3] = 1'b1;
    run_cmd(2'b01, 8'd1, 8'd2, 8'h77, 0, 1'b0);
    tbl_bool[5] = 1'b0; tbl_val[5] = 8'h33;
    run_cmd(2'b01, 8'd1, 8'd2, 8'h77, 1, 1'b0);
    run_cmd(2'b11, 8'd7, 8'd7, 8'd7, 2, 1'b1);

    // Reset in the third cycle of a READ drops it without a response.
    tbl_bool[1] = 1'b1; tbl_val[1] = 8'hC3;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00;
    bus.cmd_handle = 8'd3; bus.cmd_index = 8'd4; bus.cmd_value = 8'd0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_selector", bus.core_selector, 1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midreset_busy", busy, 0);
    check_eq("midreset_selector", bus.core_selector, 8);
    check_eq("midreset_rsp_valid", bus.rsp_valid, 0);
    check_eq("midreset_cmd_ready", bus.cmd_ready, 1);
    check_eq("midreset_handle", bus.core_queried_handle, 0);
    reset = 1'b1;
    run_cmd(2'b00, 8'd3, 8'd4, 8'd0, 0, 1'b0);

    // Randomized commands against the model.
    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      randomize_core();
      op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_cmd(op, DW'($urandom), DW'($urandom), DW'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
